bcd2bin_seq: RTL and testbench

Sequential BCD-to-binary converter using reverse double-dabble: one bit shifted right per SHIFT state, with a digit correction on each ADJUST state. It is the inverse of the team's binary-to-BCD converter. It converts operator/display-side decimal values (e.g. packed BCD thresholds and settings) into binary for the accelerometer datapath. It also rejects illegal BCD digits.

---
 rtl/bcd2bin_seq.sv | 125 ++++++++++++
 tb/tb_bcd2bin_seq.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/bcd2bin_seq.sv
// rtl/bcd2bin_seq.sv - sequential packed-BCD to binary converter (reverse double-dabble)
module bcd2bin_seq #(
  parameter int BCD_DIGITS = 4,
  parameter int BIN_WIDTH  = 14
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [4*BCD_DIGITS-1:0]   bcd,
  output logic [BIN_WIDTH-1:0]      bin,
  output logic                      ready,
  output logic                      busy,
  output logic                      err
);

  localparam int N  = 4 * BCD_DIGITS;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    ADJUST = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [N-1:0]           bcd_r_q, bcd_r_d;
  logic [N-1:0]           bin_r_q, bin_r_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BIN_WIDTH-1:0]   bin_q, bin_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;
  logic                   bad_digit;

  // Flag any raw input digit outside 0..9
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // Next-state and datapath: shift one bit per SHIFT, correct digits >= 8 per ADJUST
  always_comb begin
    state_d = state_q;
    bcd_r_d = bcd_r_q;
    bin_r_d = bin_r_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bcd_r_d = bcd;
          bin_r_d = '0;
          cnt_d   = '0;
          if (bad_digit) begin
            err_d   = 1'b1;
            bin_d   = '0;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        {bcd_r_d, bin_r_d} = {bcd_r_q, bin_r_q} >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          // Result is captured on entry to DONE so it is valid alongside ready
          bin_d   = bin_r_d[BIN_WIDTH-1:0];
          state_d = DONE;
        end else begin
          state_d = ADJUST;
        end
      end
      ADJUST: begin
        for (int i = 0; i < BCD_DIGITS; i++) begin
          if (bcd_r_q[4*i+3]) bcd_r_d[4*i +: 4] = bcd_r_q[4*i +: 4] - 4'd3;
        end
        state_d = SHIFT;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  // State and registered outputs, synchronous reset abandons any conversion
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bcd_r_q <= '0;
      bin_r_q <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_r_q <= bcd_r_d;
      bin_r_q <= bin_r_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bin   = bin_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb/tb_bcd2bin_seq.sv - directed and random checks for bcd2bin_seq
module tb_bcd2bin_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] bcd;
  logic [13:0] bin;
  logic        ready;
  logic        busy;
  logic        err;

  int passed = 0;
  int total  = 0;

  bcd2bin_seq #(.BCD_DIGITS(4), .BIN_WIDTH(14)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bcd   (bcd),
    .bin   (bin),
    .ready (ready),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Called 1 time unit after an edge; returns 1 time unit after the next edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges with ready high over a window
  task automatic count_ready(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (ready) seen++;
    end
  endtask

  // Issue start now; E0 is the next edge. Latency is edges after E0 until ready is seen.
  task automatic convert(input string tag, input logic [15:0] v, input int exp_bin,
                         input logic exp_err, input int exp_lat);
    int lat;
    start = 1'b1;
    bcd   = v;
    tick();
    start = 1'b0;
    bcd   = 16'hFFFF;
    lat   = 0;
    while (!ready && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " bin"}, int'(bin), exp_bin);
    check({tag, " err"}, int'(err), int'(exp_err));
    check({tag, " busy@ready"}, int'(busy), 1);
    tick();
    check({tag, " ready width"}, int'(ready), 0);
    check({tag, " busy after"}, int'(busy), 0);
  endtask

  initial begin
    int seen;
    int lat;
    logic [15:0] v;
    int d0, d1, d2, d3;

    reset = 1'b1;
    start = 1'b0;
    bcd   = 16'h0000;
    tick();
    tick();
    reset = 1'b0;
    check("reset bin", int'(bin), 0);
    check("reset ready", int'(ready), 0);
    check("reset busy", int'(busy), 0);
    check("reset err", int'(err), 0);
    count_ready(50, seen);
    check("idle no ready", seen, 0);

    convert("1234", 16'h1234, 1234, 1'b0, 31);
    convert("9999", 16'h9999, 9999, 1'b0, 31);
    convert("0000", 16'h0000, 0, 1'b0, 31);
    convert("0808", 16'h0808, 808, 1'b0, 31);

    convert("illegal 12A4", 16'h12A4, 0, 1'b1, 0);
    convert("after illegal 0042", 16'h0042, 42, 1'b0, 31);

    // Busy rejection: second start and changed bcd mid-conversion must be ignored
    start = 1'b1;
    bcd   = 16'h0500;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    start = 1'b1;
    bcd   = 16'h0777;
    tick();
    start = 1'b0;
    lat   = 10;
    while (!ready && lat < 40) begin
      tick();
      lat++;
    end
    check("reject latency", lat, 31);
    check("reject bin", int'(bin), 500);
    check("reject err", int'(err), 0);
    count_ready(40, seen);
    check("reject single ready", seen, 0);

    // Reset mid-operation abandons the conversion silently
    start = 1'b1;
    bcd   = 16'h4321;
    tick();
    start = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset bin", int'(bin), 0);
    check("midreset ready", int'(ready), 0);
    check("midreset busy", int'(busy), 0);
    check("midreset err", int'(err), 0);
    count_ready(50, seen);
    check("midreset no ready", seen, 0);
    convert("after reset 4321", 16'h4321, 4321, 1'b0, 31);

    // Back-to-back random legal values, each start in the cycle after the previous ready
    for (int k = 0; k < 500; k++) begin
      d0 = int'($urandom_range(0, 9));
      d1 = int'($urandom_range(0, 9));
      d2 = int'($urandom_range(0, 9));
      d3 = int'($urandom_range(0, 9));
      v  = {d3[3:0], d2[3:0], d1[3:0], d0[3:0]};
      convert($sformatf("rand%0d %h", k, v), v, d3*1000 + d2*100 + d1*10 + d0, 1'b0, 31);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
